rr_mux_reg: RTL

- Parametrised N-channel, WIDTH-bit merging mux with per-channel valid/ready handshakes.
- Selects one requesting channel per cycle, by fixed priority or round-robin arbitration, or by an external forced select.
- Registers the winner into a single-entry output stage.
- Used wherever several producers share one consumer, e.g. I-side and D-side requests merged onto one bus-interface request, or multiple writeback sources.

---
 rtl/mux_pkg.sv | 17 +
 rtl/rr_pick.sv | 58 +++++
 rtl/rr_mux_reg.sv | 96 +++++++++
 3 files changed

// File: rtl/mux_pkg.sv
// Shared types and helpers for the round-robin merging mux.
// Latency: n/a (package, no logic).
// Backpressure: n/a.
package mux_pkg;

    // Arbitration policy: lowest index wins, or round-robin from a rotating pointer.
    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_t;

    // Index width that never collapses to zero bits, so N=1 still has a 1-bit select.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational one-hot picker: fixed priority or round-robin starting at ptr.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller qualifies gnt with its own accept.
//
// Ports:
//   req     : per-channel request vector
//   ptr     : round-robin start index (ignored in ARB_FIXED), always < N
//   mode    : ARB_FIXED or ARB_RR
//   gnt     : one-hot grant (all zero when no request)
//   gnt_idx : binary index of the granted channel
//   any     : at least one request is granted
module rr_pick
    import mux_pkg::*;
#(
    parameter  int N    = 8,
    localparam int SELW = clog2_min1(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    input  logic            mode,
    output logic [N-1:0]    gnt,
    output logic [SELW-1:0] gnt_idx,
    output logic            any
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    int             shift;
    int             idx;

    // Rotate the request vector right by the start index through a doubled copy,
    // priority-encode the lowest set bit, then undo the rotation modulo N.
    always_comb begin
        shift = (mode == ARB_RR) ? int'(32'(ptr)) : 0;
        if (shift >= N) begin
            shift = 0;
        end
        dbl = {req, req} >> shift;
        rot = dbl[N-1:0];
        any = |rot;
        idx = 0;
        for (int j = N - 1; j >= 0; j--) begin
            if (rot[j]) begin
                idx = j;
            end
        end
        idx = idx + shift;
        if (idx >= N) begin
            idx = idx - N;
        end
        gnt = '0;
        for (int j = 0; j < N; j++) begin
            gnt[j] = any && (idx == j);
        end
        gnt_idx = SELW'(idx);
    end

endmodule

// File: rtl/rr_mux_reg.sv
// N-channel valid/ready merging mux with arbitration and a single registered output stage.
// Latency: one cycle from input handshake to out_valid; 1 beat/cycle sustained.
// Backpressure: out_valid && !out_ready holds the output and drops every in_ready.
//
// Ports:
//   clk, rst            : clock and synchronous active-high reset
//   in_data/in_valid    : flattened channel data (ch i at [i*WIDTH +: WIDTH]) and requests
//   in_ready            : per-channel accept, combinational from valid/force/out_ready
//   force_en/force_sel  : restrict the grant to a single channel (out-of-range -> none)
//   out_data/out_sel    : registered winning beat and its source channel
//   out_valid/out_ready : output handshake
module rr_mux_reg
    import mux_pkg::*;
#(
    parameter  int        WIDTH    = 32,
    parameter  int        N        = 8,
    parameter  arb_mode_t ARB_MODE = ARB_RR,
    localparam int        SELW     = clog2_min1(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic               force_en,
    input  logic [SELW-1:0]    force_sel,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_sel,
    output logic               out_valid,
    input  logic               out_ready
);

    logic [SELW-1:0]  ptr;
    logic [N-1:0]     force_mask;
    logic [N-1:0]     cand;
    logic [N-1:0]     gnt;
    logic [SELW-1:0]  gnt_idx;
    logic             any;
    logic             accept;
    logic [WIDTH-1:0] win_data;
    int unsigned      fsel;

    // An out-of-range force_sel matches no channel, so the mask is empty and nothing is granted.
    always_comb begin
        fsel       = 32'(force_sel);
        force_mask = '0;
        for (int i = 0; i < N; i++) begin
            force_mask[i] = (fsel == i);
        end
        cand = force_en ? (in_valid & force_mask) : in_valid;
    end

    rr_pick #(
        .N(N)
    ) u_pick (
        .req     (cand),
        .ptr     (ptr),
        .mode    (ARB_MODE),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    assign accept   = !out_valid || out_ready;
    assign in_ready = (accept && !rst) ? gnt : '0;

    always_comb begin
        win_data = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) begin
                win_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // The pointer advances past every winner regardless of mode, so round-robin order
    // picks up fairly after a forced or fixed-priority stretch.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
        end else if (accept) begin
            if (any) begin
                out_valid <= 1'b1;
                out_data  <= win_data;
                out_sel   <= gnt_idx;
                ptr       <= (gnt_idx == SELW'(N - 1)) ? '0 : gnt_idx + SELW'(1);
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
